// File: rtl/hw_load_ctrl.sv
// Halfword immediate load controller: read-modify-write passes through the shared
// register-file port, merging a halfword into the upper or lower half of rd.
module hw_load_ctrl #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] imm,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rf_req,
    input  logic              rf_gnt,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int unsigned HW = DATA_W / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_LUH = 2'b00,
        OP_LLH = 2'b01,
        OP_LIM = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    state_t            state_q, state_d;
    logic              pass_q, pass_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pass_q  <= 1'b0;
            op_q    <= OP_LUH;
            rd_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        op_d    = op_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_t'(op);
                    rd_d    = rd;
                    imm_d   = imm;
                    pass_d  = 1'b0;
                    state_d = (op_t'(op) == OP_ILL) ? S_DONE : S_ARB;
                end
            end
            S_ARB:  if (rf_gnt) state_d = S_RD;
            S_RD:   state_d = S_WR;
            S_WR: begin
                // LIM loops back for its lower-half pass without dropping rf_req
                if (op_q == OP_LIM && !pass_q) begin
                    pass_d  = 1'b1;
                    state_d = S_ARB;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic          upper_sel;
    logic [HW-1:0] upper_imm;

    assign upper_sel = (op_q == OP_LUH) || (op_q == OP_LIM && !pass_q);
    assign upper_imm = (op_q == OP_LIM) ? imm_q[DATA_W-1:HW] : imm_q[HW-1:0];

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        err      = 1'b0;
        rf_req   = 1'b0;
        rf_raddr = '0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        unique case (state_q)
            S_ARB: rf_req = 1'b1;
            S_RD: begin
                rf_req   = 1'b1;
                rf_raddr = rd_q;
            end
            S_WR: begin
                rf_req   = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = upper_sel ? {upper_imm, rf_rdata[HW-1:0]}
                                     : {rf_rdata[DATA_W-1:HW], imm_q[HW-1:0]};
            end
            S_DONE: begin
                done = 1'b1;
                err  = (op_q == OP_ILL);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hw_load_ctrl.sv
// Bench for hw_load_ctrl: a synchronous-read register file plus a transaction-level
// model that lays out the expected per-cycle output trace for each load.
module tb_hw_load_ctrl;

    localparam int DW = 10;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst, start, rf_gnt;
    logic [1:0]    op;
    logic [AW-1:0] rd;
    logic [DW-1:0] imm;
    logic          busy, done, err, rf_req, rf_we;
    logic [AW-1:0] rf_raddr, rf_waddr;
    logic [DW-1:0] rf_rdata, rf_wdata;

    always #5 clk = ~clk;

    hw_load_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rd(rd), .imm(imm),
        .busy(busy), .done(done), .err(err),
        .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    logic [DW-1:0] mem     [8];
    logic [DW-1:0] exp_mem [8];

    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
        rf_rdata <= mem[rf_raddr];
    end

    int total = 0;
    int bad   = 0;

    // outs = {busy, done, err, req, we, raddr[2:0], waddr[2:0], wdata[9:0]}
    typedef struct packed {
        logic        arb;
        logic        gnt;
        logic [20:0] outs;
    } ent_t;

    ent_t         exp_q[$];
    logic [12:0]  wlog[$];
    int           done_at;
    int           req_cnt;

    function automatic logic [20:0] obs();
        return {busy, done, err, rf_req, rf_we, rf_raddr, rf_waddr, rf_wdata};
    endfunction

    function automatic logic [20:0] pk(bit b, bit d, bit e, bit q, bit w,
                                       logic [2:0] ra, logic [2:0] wa, logic [9:0] wd);
        return {b, d, e, q, w, ra, wa, wd};
    endfunction

    function automatic void build(logic [1:0] o, logic [2:0] r, logic [9:0] im, int s0, int s1);
        logic [9:0] cur, w;
        int np, st;
        exp_q.delete();
        cur = exp_mem[r];
        if (o == 2'b11) begin
            exp_q.push_back({1'b0, 1'b0, pk(1, 1, 1, 0, 0, 3'd0, 3'd0, 10'd0)});
            return;
        end
        np = (o == 2'b10) ? 2 : 1;
        for (int p = 0; p < np; p++) begin
            st = (p == 0) ? s0 : s1;
            for (int k = 0; k < st; k++)
                exp_q.push_back({1'b1, 1'b0, pk(1, 0, 0, 1, 0, 3'd0, 3'd0, 10'd0)});
            exp_q.push_back({1'b1, 1'b1, pk(1, 0, 0, 1, 0, 3'd0, 3'd0, 10'd0)});
            exp_q.push_back({1'b0, 1'b0, pk(1, 0, 0, 1, 0, r, 3'd0, 10'd0)});
            case (o)
                2'b00:   w = {im[4:0], cur[4:0]};
                2'b01:   w = {cur[9:5], im[4:0]};
                default: w = (p == 0) ? {im[9:5], cur[4:0]} : {cur[9:5], im[4:0]};
            endcase
            exp_q.push_back({1'b0, 1'b0, pk(1, 0, 0, 1, 1, 3'd0, r, w)});
            cur = w;
        end
        exp_q.push_back({1'b0, 1'b0, pk(1, 1, 0, 0, 0, 3'd0, 3'd0, 10'd0)});
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [2:0] r, input logic [9:0] im,
                          input int s0, input int s1, input int abort_at, input bit strays,
                          input string tag);
        logic [20:0] e;
        build(o, r, im, s0, s1);
        wlog.delete();
        done_at = -1;
        req_cnt = 0;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rd     = r;
        imm    = im;
        rf_gnt = 1'($urandom);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            e = exp_q[k].outs;
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL %s cycle N+%0d: got %h want %h", tag, k + 1, obs(), e);
            end
            if (rf_we) wlog.push_back({rf_waddr, rf_wdata});
            if (rf_req) req_cnt++;
            if (done && done_at < 0) done_at = k + 1;
            if (e[16]) exp_mem[r] = e[9:0];
            rf_gnt = exp_q[k].arb ? exp_q[k].gnt : 1'($urandom);
            if (k == abort_at) begin
                rst   = 1'b1;
                start = 1'b0;
                break;
            end
            if (strays && k + 1 < exp_q.size()) begin
                start = 1'($urandom);
                op    = 2'($urandom);
                rd    = 3'($urandom);
                imm   = 10'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (obs() !== 21'd0) begin
            bad++;
            $display("FAIL %s idle_after: got %h want %h", tag, obs(), 21'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        total++;
        if (mem[r] !== exp_mem[r]) begin
            bad++;
            $display("FAIL %s reg_value r%0d: got %h want %h", tag, r, mem[r], exp_mem[r]);
        end
    endtask

    task automatic preload(input logic [2:0] r, input logic [9:0] v);
        @(negedge clk);
        mem[r]     = v;
        exp_mem[r] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        rd    = 3'd3;
        imm   = 10'h3FF;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        total++;
        if (obs() !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", obs(), 21'd0);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_beats_start: busy got %b want 0", busy);
        end
    endtask

    task automatic test_luh();
        preload(3'd3, 10'h01F);
        run_op(2'b00, 3'd3, {5'($urandom), 5'b01011}, 0, 0, -1, 1'b0, "luh");
        total++;
        if (wlog.size() != 1 || wlog[0] !== {3'd3, 10'h17F}) begin
            bad++;
            $display("FAIL luh_write: got %0d writes first %h want 1 write %h", wlog.size(),
                     (wlog.size() > 0) ? wlog[0] : 13'h0, {3'd3, 10'h17F});
        end
        total++;
        if (done_at != 4) begin
            bad++;
            $display("FAIL luh_done_cycle: got N+%0d want N+4", done_at);
        end
    endtask

    task automatic test_llh();
        preload(3'd2, 10'h3E0);
        run_op(2'b01, 3'd2, {5'($urandom), 5'b00101}, 0, 0, -1, 1'b0, "llh");
        total++;
        if (mem[2] !== 10'h3E5 || done_at != 4) begin
            bad++;
            $display("FAIL llh_result: got r2=%h done N+%0d want 3e5 N+4", mem[2], done_at);
        end
    endtask

    task automatic test_lim();
        preload(3'd1, 10'h000);
        run_op(2'b10, 3'd1, 10'h2A5, 0, 0, -1, 1'b0, "lim");
        total++;
        if (wlog.size() != 2 || wlog[0] !== {3'd1, 10'h2A0} || wlog[1] !== {3'd1, 10'h2A5}) begin
            bad++;
            $display("FAIL lim_writes: got %0d writes want 2 (2a0 then 2a5)", wlog.size());
        end
        total++;
        if (req_cnt != 6 || done_at != 7) begin
            bad++;
            $display("FAIL lim_req_done: got req %0d done N+%0d want 6 N+7", req_cnt, done_at);
        end
    endtask

    task automatic test_stall();
        preload(3'd5, 10'($urandom));
        run_op(2'b00, 3'd5, 10'h0A7, 3, 0, -1, 1'b1, "stall");
        total++;
        if (done_at != 7 || wlog.size() != 1) begin
            bad++;
            $display("FAIL stall_timing: got done N+%0d writes %0d want N+7 1", done_at, wlog.size());
        end
    endtask

    task automatic test_illegal();
        run_op(2'b11, 3'd4, 10'h155, 0, 0, -1, 1'b0, "illegal");
        total++;
        if (done_at != 1 || req_cnt != 0 || wlog.size() != 0) begin
            bad++;
            $display("FAIL illegal_op: got done N+%0d req %0d writes %0d want N+1 0 0",
                     done_at, req_cnt, wlog.size());
        end
    endtask

    task automatic test_abort();
        int seen;
        preload(3'd1, 10'h000);
        run_op(2'b10, 3'd1, 10'h2A5, 0, 0, 3, 1'b0, "abort");
        total++;
        if (mem[1] !== 10'h2A0) begin
            bad++;
            $display("FAIL abort_partial: got r1=%h want 2a0", mem[1]);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
        end
        run_op(2'b01, 3'd1, 10'h00C, 0, 0, -1, 1'b0, "after_abort");
        total++;
        if (mem[1] !== 10'h2AC || done_at != 4) begin
            bad++;
            $display("FAIL after_abort: got r1=%h done N+%0d want 2ac N+4", mem[1], done_at);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom), 3'($urandom), 10'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), -1, 1'b1, "random");
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        rd     = '0;
        imm    = '0;
        rf_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem[i]     = '0;
            exp_mem[i] = '0;
        end
        test_reset();
        test_luh();
        test_llh();
        test_lim();
        test_stall();
        test_illegal();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
